// File: rtl/nios_dbg_scan_pkg.sv
// Shared types and constants for the on-chip debug scan master.
// IR codes match the Nios II debug module's virtual-JTAG instruction set.
package nios_dbg_scan_pkg;

  localparam int unsigned SR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } scan_state_e;

endpackage

// File: rtl/nios_dbg_tck_gen.sv
// Divides clk into a tck period of 2*TCK_DIV cycles (low half first) and flags
// the cycles whose closing edge is a tck rising or falling point.
module nios_dbg_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);

  logic [CW-1:0] cnt;

  // Pulses mark the cycle before the edge at which the period boundary happens.
  assign fall_pulse = enable && (cnt == '0);
  assign rise_pulse = enable && (cnt == HALF);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (rise_pulse)
        tck <= 1'b1;
      else if (fall_pulse)
        tck <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_dbg_scan_master.sv
// On-chip JTAG scan initiator: per command, one IR update and one data scan
// through the virtual-JTAG strobes, returning the captured tdo word.
module nios_dbg_scan_master
  import nios_dbg_scan_pkg::*;
#(
  parameter int unsigned SR_WIDTH = SR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int unsigned BCW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(SR_WIDTH - 1);

  scan_state_e        state;
  logic [SR_WIDTH-1:0] shreg;
  logic [BCW-1:0]     bit_cnt;
  logic               rti_cnt;
  logic               tck_en;
  logic               tck_rise;
  logic               tck_fall;

  assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

  nios_dbg_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (tck_en),
    .tck       (vji_tck),
    .rise_pulse(tck_rise),
    .fall_pulse(tck_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_tdi    <= 1'b0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
      vji_ir_in  <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            vji_ir_in <= cmd_ir;
            shreg     <= cmd_data;
            cmd_ready <= 1'b0;
            state     <= ST_UIR;
          end
        end
        // First period boundary after accept opens UIR; vji_uir tells the two apart.
        ST_UIR: begin
          if (tck_fall) begin
            if (!vji_uir) begin
              vji_uir <= 1'b1;
            end else begin
              vji_uir <= 1'b0;
              vji_cdr <= 1'b1;
              state   <= ST_CDR;
            end
          end
        end
        ST_CDR: begin
          if (tck_rise)
            rsp_ir_out <= vji_ir_out;
          if (tck_fall) begin
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= shreg[0];
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tck_rise)
            shreg <= {vji_tdo, shreg[SR_WIDTH-1:1]};
          if (tck_fall) begin
            if (bit_cnt == BIT_LAST) begin
              vji_sdr <= 1'b0;
              vji_tdi <= 1'b0;
              vji_udr <= 1'b1;
              state   <= ST_UDR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              vji_tdi <= shreg[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
            vji_udr <= 1'b0;
            vji_rti <= 1'b1;
            rti_cnt <= 1'b0;
            state   <= ST_RTI;
          end
        end
        ST_RTI: begin
          if (tck_fall) begin
            if (rti_cnt) begin
              vji_rti   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= shreg;
              state     <= ST_RESP;
            end else begin
              rti_cnt <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_dbg_scan_master.sv
// Bench for nios_dbg_scan_master: two instances (TCK_DIV 4 and 1), each driving
// a behavioural 38-bit target data register with capture and update.
module tb_nios_dbg_scan_master;
  import nios_dbg_scan_pkg::*;

  localparam int W = 38;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [1:0]   cmd_ir    [2];
  logic [W-1:0] cmd_data  [2];
  logic         rsp_valid [2];
  logic         rsp_ready [2];
  logic [W-1:0] rsp_data  [2];
  logic [1:0]   rsp_ir_out[2];
  logic         vji_tck   [2];
  logic         vji_tdi   [2];
  logic         vji_uir   [2];
  logic         vji_cdr   [2];
  logic         vji_sdr   [2];
  logic         vji_udr   [2];
  logic         vji_rti   [2];
  logic [1:0]   vji_ir_in [2];
  logic         vji_tdo   [2];
  logic [1:0]   vji_ir_out[2];

  logic [W-1:0] dr [2];
  logic [W-1:0] upd[2];
  logic [W-1:0] cap[2];
  logic [1:0]   ir_stat[2];
  logic         tck_q[2] = '{1'b0, 1'b0};
  int n_uir[2] = '{0, 0};
  int n_cdr[2] = '{0, 0};
  int n_sdr[2] = '{0, 0};
  int n_udr[2] = '{0, 0};
  int n_rti[2] = '{0, 0};
  int cyc = 0;

  int n_chk = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned DIV = (g == 0) ? 4 : 1;
    nios_dbg_scan_master #(
      .SR_WIDTH(W),
      .IR_WIDTH(2),
      .TCK_DIV (DIV)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_ir    (cmd_ir[g]),
      .cmd_data  (cmd_data[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_ir_out(rsp_ir_out[g]),
      .vji_tck   (vji_tck[g]),
      .vji_tdi   (vji_tdi[g]),
      .vji_uir   (vji_uir[g]),
      .vji_cdr   (vji_cdr[g]),
      .vji_sdr   (vji_sdr[g]),
      .vji_udr   (vji_udr[g]),
      .vji_rti   (vji_rti[g]),
      .vji_ir_in (vji_ir_in[g]),
      .vji_tdo   (vji_tdo[g]),
      .vji_ir_out(vji_ir_out[g])
    );
    assign vji_tdo[g]    = dr[g][0];
    assign vji_ir_out[g] = vji_cdr[g] ? ir_stat[g] : 2'b00;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Target reacts one clk after each tck rising point, like TCK-domain flops.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (vji_tck[k] && !tck_q[k]) begin
        if (vji_cdr[k])
          dr[k] <= cap[k];
        else if (vji_sdr[k])
          dr[k] <= {vji_tdi[k], dr[k][W-1:1]};
        if (vji_udr[k])
          upd[k] <= dr[k];
        n_uir[k] <= n_uir[k] + (vji_uir[k] ? 1 : 0);
        n_cdr[k] <= n_cdr[k] + (vji_cdr[k] ? 1 : 0);
        n_sdr[k] <= n_sdr[k] + (vji_sdr[k] ? 1 : 0);
        n_udr[k] <= n_udr[k] + (vji_udr[k] ? 1 : 0);
        n_rti[k] <= n_rti[k] + (vji_rti[k] ? 1 : 0);
      end
      tck_q[k] <= vji_tck[k];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input int k, input logic [1:0] ir, input logic [W-1:0] data,
                         input logic [W-1:0] capv, input logic [1:0] irst, input int hold);
    int div, exp_lat, acc, t;
    int s_uir, s_cdr, s_sdr, s_udr, s_rti;
    int ir_bad, tdi_bad, multi, tog_bad, stab_bad;
    bit got, act, prev_act, prev_tck;
    logic [W-1:0] held;
    div = (k == 0) ? 4 : 1;
    exp_lat = 1 + (W + 5) * 2 * div;
    ir_bad = 0; tdi_bad = 0; multi = 0; tog_bad = 0; stab_bad = 0;
    s_uir = n_uir[k]; s_cdr = n_cdr[k]; s_sdr = n_sdr[k]; s_udr = n_udr[k]; s_rti = n_rti[k];
    cap[k] = capv;
    ir_stat[k] = irst;
    t = 0;
    while (!cmd_ready[k] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready_wait", 64'(cmd_ready[k]), 64'd1);
    cmd_valid[k] = 1'b1;
    cmd_ir[k]    = ir;
    cmd_data[k]  = data;
    rsp_ready[k] = (hold == 0);
    @(negedge clk);
    acc = cyc;
    cmd_valid[k] = 1'b0;
    cmd_ir[k]    = ~ir;
    cmd_data[k]  = ~data;
    check_eq("busy_ready", 64'(cmd_ready[k]), 64'd0);
    got = 1'b0; t = 0; prev_act = 1'b0; prev_tck = 1'b0;
    while (t < 2 * exp_lat) begin
      if (rsp_valid[k]) begin
        got = 1'b1;
        break;
      end
      if (vji_ir_in[k] !== ir) ir_bad++;
      if (!vji_sdr[k] && vji_tdi[k]) tdi_bad++;
      if (int'(vji_uir[k]) + int'(vji_cdr[k]) + int'(vji_sdr[k]) + int'(vji_udr[k]) + int'(vji_rti[k]) > 1)
        multi++;
      act = vji_uir[k] | vji_cdr[k] | vji_sdr[k] | vji_udr[k] | vji_rti[k];
      if (k == 1 && act && prev_act && vji_tck[k] == prev_tck) tog_bad++;
      prev_act = act;
      prev_tck = vji_tck[k];
      @(negedge clk);
      t++;
    end
    check_eq("rsp_seen", 64'(got), 64'd1);
    check_eq("latency", 64'(cyc - acc), 64'(exp_lat));
    check_eq("rsp_data", 64'(rsp_data[k]), 64'(capv));
    check_eq("rsp_ir_out", 64'(rsp_ir_out[k]), 64'(irst));
    check_eq("target_update", 64'(upd[k]), 64'(data));
    check_eq("n_uir", 64'(n_uir[k] - s_uir), 64'd1);
    check_eq("n_cdr", 64'(n_cdr[k] - s_cdr), 64'd1);
    check_eq("n_sdr", 64'(n_sdr[k] - s_sdr), 64'(W));
    check_eq("n_udr", 64'(n_udr[k] - s_udr), 64'd1);
    check_eq("n_rti", 64'(n_rti[k] - s_rti), 64'd2);
    check_eq("ir_in_hold", 64'(ir_bad), 64'd0);
    check_eq("tdi_idle", 64'(tdi_bad), 64'd0);
    check_eq("strobe_excl", 64'(multi), 64'd0);
    if (k == 1) check_eq("tck_toggle", 64'(tog_bad), 64'd0);
    if (hold > 0) begin
      held = rsp_data[k];
      cmd_valid[k] = 1'b1;
      cmd_data[k]  = W'({$urandom(), $urandom()});
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== held || cmd_ready[k] !== 1'b0 || vji_uir[k] !== 1'b0)
          stab_bad++;
      end
      check_eq("hold_stable", 64'(stab_bad), 64'd0);
      cmd_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check_eq("rsp_done", 64'(rsp_valid[k]), 64'd0);
    check_eq("idle_ready", 64'(cmd_ready[k]), 64'd1);
  endtask

  task automatic reset_mid_shift();
    int s, t, bad;
    s = n_sdr[0];
    cap[0] = W'({$urandom(), $urandom()});
    ir_stat[0] = 2'b01;
    cmd_valid[0] = 1'b1;
    cmd_ir[0]    = IR_BREAK;
    cmd_data[0]  = W'({$urandom(), $urandom()});
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    t = 0;
    while (n_sdr[0] - s < 17 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("shift_reached", 64'(n_sdr[0] - s), 64'd17);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_vji", 64'({vji_tck[0], vji_tdi[0], vji_uir[0], vji_cdr[0], vji_sdr[0],
                             vji_udr[0], vji_rti[0], vji_ir_in[0]}), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (rsp_valid[0] || vji_uir[0]) bad++;
    end
    check_eq("rst_dropped", 64'(bad), 64'd0);
    rsp_ready[0] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_ir[i]    = 2'b00;
      cmd_data[i]  = '0;
      rsp_ready[i] = 1'b0;
      cap[i]       = '0;
      ir_stat[i]   = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_cmd_ready", 64'(cmd_ready[i]), 64'd1);
      check_eq("reset_rsp_valid", 64'(rsp_valid[i]), 64'd0);
      check_eq("reset_rsp_data", 64'(rsp_data[i]), 64'd0);
      check_eq("reset_rsp_ir_out", 64'(rsp_ir_out[i]), 64'd0);
      check_eq("reset_vji", 64'({vji_tck[i], vji_tdi[i], vji_uir[i], vji_cdr[i], vji_sdr[i],
                                 vji_udr[i], vji_rti[i], vji_ir_in[i]}), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_cmd(0, IR_BREAK, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 2'b11, 0);
    run_cmd(1, IR_OCIMEM, 38'h1, W'({$urandom(), $urandom()}), 2'b11, 0);
    run_cmd(0, IR_TRACEMEM, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 2'b10, 20);
    run_cmd(0, IR_TRACECTRL, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 2'b01, 0);
    reset_mid_shift();
    run_cmd(0, IR_BREAK, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 2'b11, 0);

    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(1, 0));
      run_cmd(k, 2'($urandom()), W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
              2'($urandom()), int'($urandom_range(4, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
